fpu_link_host: RTL and testbench

- Host-side master for the nibble-serial FPU chip pin protocol.
- Accepts a 16-bit operand pair and an op select over a valid/ready request interface.
- Serialises the operands onto the chip input pins 4 bits per cycle, then collects the 2-byte result from the chip output pins.
- Returns the 16-bit result and a validity flag over a valid/ready response interface.
- Sits between a test or host controller and the chip boundary (chip_in feeds the chip's io_in; chip_out comes from its io_out).

---
 rtl/fpu_link_host.sv | 160 ++++++++++++++++
 tb/tb_fpu_link_host.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_link_host.sv
// fpu_link_host: host-side master for the nibble-serial FPU chip pin protocol.
// Optional feature macro FPU_LINK_STATS_EN adds saturating stat_ops/stat_inv counters.
module fpu_link_host #(
   parameter int ENABLE_CYCLES = 6,
   parameter int RSP_LATENCY   = 1,
   parameter int STAT_W        = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [15:0]       req_a,
   input  logic [15:0]       req_b,
   input  logic              req_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [15:0]       rsp_data,
   output logic              rsp_flag,
   output logic [11:0]       chip_in,
   input  logic [11:0]       chip_out
`ifdef FPU_LINK_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_ops,
   output logic [STAT_W-1:0] stat_inv
`endif
);

   localparam int CNT_MAX = (ENABLE_CYCLES > RSP_LATENCY) ? ENABLE_CYCLES : RSP_LATENCY;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(ENABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((RSP_LATENCY > 0) ? RSP_LATENCY - 1 : 0);

   typedef enum logic [2:0] {IDLE, SEND, WAIT, CAP_LO, CAP_HI, DONE} state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [11:0]      a_sh_reg;
   logic [11:0]      b_sh_reg;
   logic             op_reg;
   logic             req_ready_reg;
   logic             rsp_valid_reg;
   logic             rsp_flag_reg;
   logic [15:0]      rsp_data_reg;
   logic [11:0]      chip_in_reg;
   logic             unused_chip_bits;

   function automatic logic [11:0] send_word(logic op, logic [3:0] b_nib, logic [3:0] a_nib);
      return {2'b00, 1'b1, op, b_nib, a_nib};
   endfunction

   function automatic logic [11:0] hold_word(logic op);
      return {3'b000, op, 8'h00};
   endfunction

   // chip_in is registered one cycle ahead: each transition loads the word for the state being entered.
   // The operand shift registers drain to zero after four nibbles, so extra enable cycles carry zeros.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         a_sh_reg      <= '0;
         b_sh_reg      <= '0;
         op_reg        <= 1'b0;
         req_ready_reg <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_flag_reg  <= 1'b0;
         rsp_data_reg  <= '0;
         chip_in_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid && req_ready_reg) begin
                  state_reg     <= SEND;
                  cnt_reg       <= '0;
                  op_reg        <= req_op;
                  a_sh_reg      <= req_a[15:4];
                  b_sh_reg      <= req_b[15:4];
                  req_ready_reg <= 1'b0;
                  chip_in_reg   <= send_word(req_op, req_b[3:0], req_a[3:0]);
               end else begin
                  req_ready_reg <= 1'b1;
                  chip_in_reg   <= '0;
               end
            end
            SEND: begin
               if (cnt_reg == SEND_LAST) begin
                  cnt_reg     <= '0;
                  chip_in_reg <= hold_word(op_reg);
                  state_reg   <= (RSP_LATENCY == 0) ? CAP_LO : WAIT;
               end else begin
                  cnt_reg     <= cnt_reg + CNT_W'(1);
                  chip_in_reg <= send_word(op_reg, b_sh_reg[3:0], a_sh_reg[3:0]);
                  a_sh_reg    <= a_sh_reg >> 4;
                  b_sh_reg    <= b_sh_reg >> 4;
               end
            end
            WAIT: begin
               if (cnt_reg == WAIT_LAST) begin
                  state_reg <= CAP_LO;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            CAP_LO: begin
               rsp_data_reg[7:0] <= chip_out[7:0];
               rsp_flag_reg      <= chip_out[8];
               state_reg         <= CAP_HI;
            end
            CAP_HI: begin
               rsp_data_reg[15:8] <= chip_out[7:0];
               chip_in_reg        <= '0;
               rsp_valid_reg      <= 1'b1;
               state_reg          <= DONE;
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  req_ready_reg <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg   <= IDLE;
               chip_in_reg <= '0;
            end
         endcase
      end
   end

   assign req_ready        = req_ready_reg;
   assign rsp_valid        = rsp_valid_reg;
   assign rsp_data         = rsp_data_reg;
   assign rsp_flag         = rsp_flag_reg;
   assign chip_in          = chip_in_reg;
   assign unused_chip_bits = ^chip_out[11:9];

`ifdef FPU_LINK_STATS_EN
   logic       rsp_fire;
   logic [1:0] stat_inc;

   assign rsp_fire = rsp_valid_reg && rsp_ready;
   assign stat_inc = {rsp_fire & ~rsp_flag_reg, rsp_fire};

   // Index 0 counts every handshake, index 1 only those carrying an invalid result.
   for (genvar gi = 0; gi < 2; gi++) begin : g_stat
      logic [STAT_W-1:0] cnt_reg;
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            cnt_reg <= '0;
         end else if (stat_inc[gi] && (cnt_reg != {STAT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + STAT_W'(1);
         end
      end
   end

   assign stat_ops = g_stat[0].cnt_reg;
   assign stat_inv = g_stat[1].cnt_reg;
`endif

endmodule

// File: tb/tb_fpu_link_host.sv
// Bench for fpu_link_host: two configurations (6/1 and 4/3) driven with random traffic
// against a transaction-timeline model, plus directed literal expectations.
`timescale 1ns/1ps
module tb_fpu_link_host;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_pass = 0;

   function automatic int ec_of(int g);   return (g == 0) ? 6 : 4;   endfunction
   function automatic int rl_of(int g);   return (g == 0) ? 1 : 3;   endfunction
   function automatic int sw_of(int g);   return (g == 0) ? 16 : 2;  endfunction
   function automatic int tdone(int g);   return ec_of(g) + rl_of(g) + 3; endfunction
   function automatic int tlo(int g);     return ec_of(g) + rl_of(g) + 1; endfunction

   function automatic logic [15:0] d_a(int g);    return (g == 0) ? 16'h3C00 : 16'h1234; endfunction
   function automatic logic [15:0] d_b(int g);    return (g == 0) ? 16'h4000 : 16'h5678; endfunction
   function automatic logic [7:0]  d_lo(int g);   return (g == 0) ? 8'h00 : 8'hAB; endfunction
   function automatic logic [7:0]  d_hi(int g);   return (g == 0) ? 8'h42 : 8'hCD; endfunction
   function automatic logic        d_fl(int g);   return (g == 0) ? 1'b1 : 1'b0; endfunction
   function automatic logic [15:0] d_data(int g); return (g == 0) ? 16'h4200 : 16'hCDAB; endfunction

   function automatic logic [7:0] lit_send(int g, int k);
      logic [7:0] v;
      v = 8'h00;
      if (g == 0) begin
         case (k)
            2: v = 8'h0C;
            3: v = 8'h43;
            default: v = 8'h00;
         endcase
      end else begin
         case (k)
            0: v = 8'h84;
            1: v = 8'h73;
            2: v = 8'h62;
            3: v = 8'h51;
            default: v = 8'h00;
         endcase
      end
      return v;
   endfunction

   function automatic logic [3:0] nib(logic [15:0] x, int k);
      logic [15:0] s;
      s = x >> (4 * k);
      return s[3:0];
   endfunction

   function automatic void chk(string name, int g, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s inst%0d @%0t: got %0h required %0h", name, g, $time, act, exp);
   endfunction

   logic [1:0]        reset_n_w;
   logic [1:0]        req_valid_w;
   logic [1:0]        req_ready_w;
   logic [1:0][15:0]  req_a_w;
   logic [1:0][15:0]  req_b_w;
   logic [1:0]        req_op_w;
   logic [1:0]        rsp_valid_w;
   logic [1:0]        rsp_ready_w;
   logic [1:0][15:0]  rsp_data_w;
   logic [1:0]        rsp_flag_w;
   logic [1:0][11:0]  chip_in_w;
   logic [1:0][11:0]  chip_out_w;
   logic [1:0][15:0]  stat_ops_w;
   logic [1:0][15:0]  stat_inv_w;

   for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
      localparam int SW = sw_of(gi);
      logic [SW-1:0] so;
      logic [SW-1:0] si;
`ifndef FPU_LINK_STATS_EN
      assign so = '0;
      assign si = '0;
`endif
      assign stat_ops_w[gi] = 16'(so);
      assign stat_inv_w[gi] = 16'(si);

      fpu_link_host #(
         .ENABLE_CYCLES(ec_of(gi)),
         .RSP_LATENCY  (rl_of(gi)),
         .STAT_W       (SW)
      ) u_dut (
         .clock    (clock),
         .reset_n  (reset_n_w[gi]),
         .req_valid(req_valid_w[gi]),
         .req_ready(req_ready_w[gi]),
         .req_a    (req_a_w[gi]),
         .req_b    (req_b_w[gi]),
         .req_op   (req_op_w[gi]),
         .rsp_valid(rsp_valid_w[gi]),
         .rsp_ready(rsp_ready_w[gi]),
         .rsp_data (rsp_data_w[gi]),
         .rsp_flag (rsp_flag_w[gi]),
         .chip_in  (chip_in_w[gi]),
         .chip_out (chip_out_w[gi])
`ifdef FPU_LINK_STATS_EN
         ,
         .stat_ops (so),
         .stat_inv (si)
`endif
      );
   end

   // Model state per configuration: t counts cycles since the accepting edge (1 = first enable cycle).
   bit          busy     [2];
   int          t        [2];
   bit          rdy_exp  [2];
   logic [15:0] m_a      [2];
   logic [15:0] m_b      [2];
   logic        m_op     [2];
   logic [7:0]  m_lo     [2];
   logic [7:0]  m_hi     [2];
   logic        m_fl     [2];
   logic [15:0] exp_data [2];
   logic        exp_flag [2];
   int          acc_n    [2];
   int          hs_n     [2];
   int          done_wait[2];
   int          rst_hold [2];
   bit          rst_done [2];
   bit          lat_seen [2];
   bit          stat_seen[2];
   int          hs_cyc   [2];
   longint      exp_ops  [2];
   longint      exp_inv  [2];

   localparam int N_TXN = 40;

   initial begin
      logic [11:0] exp_ci;
      bit          want_rst [2];
      int          k;
      int          cur;
      longint      smax;

      for (int g = 0; g < 2; g++) begin
         reset_n_w[g] = 1'b0; req_valid_w[g] = 1'b0; req_a_w[g] = '0; req_b_w[g] = '0;
         req_op_w[g] = 1'b0; rsp_ready_w[g] = 1'b0; chip_out_w[g] = '0;
         busy[g] = 0; t[g] = 0; rdy_exp[g] = 0; exp_data[g] = '0; exp_flag[g] = 1'b0;
         acc_n[g] = 0; hs_n[g] = 0; done_wait[g] = 0; rst_hold[g] = 3; rst_done[g] = 0;
         lat_seen[g] = 0; stat_seen[g] = 0; hs_cyc[g] = 0; exp_ops[g] = 0; exp_inv[g] = 0;
         m_a[g] = '0; m_b[g] = '0; m_op[g] = 1'b0; m_lo[g] = '0; m_hi[g] = '0; m_fl[g] = 1'b0;
      end

      for (int cyc = 0; cyc < 6000 && (acc_n[0] < N_TXN || acc_n[1] < N_TXN); cyc++) begin
         @(negedge clock);
         for (int g = 0; g < 2; g++) begin
            want_rst[g] = 0;
            // Expected outputs for the current cycle
            exp_ci = 12'h000;
            if (busy[g] && t[g] >= 1 && t[g] <= ec_of(g)) begin
               k = t[g] - 1;
               exp_ci = {2'b00, 1'b1, m_op[g],
                         (k < 4) ? nib(m_b[g], k) : 4'h0,
                         (k < 4) ? nib(m_a[g], k) : 4'h0};
            end else if (busy[g] && t[g] > ec_of(g) && t[g] < tdone(g)) begin
               exp_ci = {3'b000, m_op[g], 8'h00};
            end
            chk("chip_in",   g, 32'(chip_in_w[g]),   32'(exp_ci));
            chk("req_ready", g, 32'(req_ready_w[g]), 32'(rdy_exp[g]));
            chk("rsp_valid", g, 32'(rsp_valid_w[g]), 32'(busy[g] && t[g] == tdone(g)));
            chk("rsp_data",  g, 32'(rsp_data_w[g]),  32'(exp_data[g]));
            chk("rsp_flag",  g, 32'(rsp_flag_w[g]),  32'(exp_flag[g]));
`ifdef FPU_LINK_STATS_EN
            chk("stat_ops",  g, 32'(stat_ops_w[g]),  32'(exp_ops[g]));
            chk("stat_inv",  g, 32'(stat_inv_w[g]),  32'(exp_inv[g]));
            if (!stat_seen[g] && hs_n[g] == ((g == 0) ? 3 : 4)) begin
               stat_seen[g] = 1;
               chk("lit_stat_ops", g, 32'(stat_ops_w[g]), 32'd3);
               if (g == 0) chk("lit_stat_inv", g, 32'(stat_inv_w[g]), 32'd2);
            end
`endif
            // Hand-computed expectations for the first (directed) transaction
            if (busy[g] && acc_n[g] == 1 && t[g] >= 1 && t[g] <= ec_of(g)) begin
               chk("lit_send_byte", g, 32'(chip_in_w[g][7:0]), 32'(lit_send(g, t[g] - 1)));
               chk("lit_en_op",     g, 32'(chip_in_w[g][9:8]), 32'd3);
            end
            if (acc_n[g] == 1 && rsp_valid_w[g] && !lat_seen[g]) begin
               lat_seen[g] = 1;
               chk("lit_latency", g, 32'(t[g]), 32'd10);
               chk("lit_data",    g, 32'(rsp_data_w[g]), 32'(d_data(g)));
               chk("lit_flag",    g, 32'(rsp_flag_w[g]), 32'(d_fl(g)));
            end

            // Chip model: result bytes only on the capture cycles, noise elsewhere
            if (busy[g] && t[g] == tlo(g))
               chip_out_w[g] = {3'($urandom), m_fl[g], m_lo[g]};
            else if (busy[g] && t[g] == tlo(g) + 1)
               chip_out_w[g] = {4'($urandom), m_hi[g]};
            else
               chip_out_w[g] = 12'($urandom);

            // Request / response stimulus
            if (rst_hold[g] > 0) begin
               reset_n_w[g] = 1'b0;
               rst_hold[g]--;
            end else begin
               reset_n_w[g] = 1'b1;
            end
            cur = acc_n[g] - 1;
            if (!reset_n_w[g]) req_valid_w[g] = 1'b0;
            else if (!busy[g] && acc_n[g] < 4) req_valid_w[g] = 1'b1;
            else req_valid_w[g] = ($urandom_range(0, 3) != 0);
            if (!busy[g] && acc_n[g] == 0) begin
               req_a_w[g] = d_a(g); req_b_w[g] = d_b(g); req_op_w[g] = 1'b1;
            end else begin
               req_a_w[g] = 16'($urandom); req_b_w[g] = 16'($urandom);
               req_op_w[g] = (!busy[g] && (acc_n[g] == 2 || acc_n[g] == 3)) ? 1'b0 : 1'($urandom);
            end
            if (busy[g] && cur == 1) rsp_ready_w[g] = (done_wait[g] >= 5);
            else if (busy[g] && (cur == 2 || cur == 3)) rsp_ready_w[g] = 1'b1;
            else rsp_ready_w[g] = ($urandom_range(0, 3) != 0);

            // Advance the model across the coming rising edge
            if (!reset_n_w[g]) begin
               busy[g] = 0; rdy_exp[g] = 0; exp_data[g] = '0; exp_flag[g] = 1'b0;
               exp_ops[g] = 0; exp_inv[g] = 0;
            end else if (!busy[g]) begin
               if (rdy_exp[g] && req_valid_w[g]) begin
                  if (acc_n[g] == 3) chk("lit_b2b_gap", g, 32'(cyc - hs_cyc[g]), 32'd1);
                  busy[g] = 1; t[g] = 1; rdy_exp[g] = 0; done_wait[g] = 0;
                  m_a[g] = req_a_w[g]; m_b[g] = req_b_w[g]; m_op[g] = req_op_w[g];
                  if (acc_n[g] == 0) begin
                     m_lo[g] = d_lo(g); m_hi[g] = d_hi(g); m_fl[g] = d_fl(g);
                  end else begin
                     m_lo[g] = 8'($urandom); m_hi[g] = 8'($urandom);
                     m_fl[g] = (g == 0 && acc_n[g] < 3) ? 1'b0 : 1'($urandom);
                  end
                  acc_n[g]++;
               end else begin
                  rdy_exp[g] = 1;
               end
            end else begin
               if (t[g] == tlo(g)) begin
                  exp_data[g][7:0] = m_lo[g]; exp_flag[g] = m_fl[g];
               end
               if (t[g] == tlo(g) + 1) exp_data[g][15:8] = m_hi[g];
               if (t[g] == tdone(g)) begin
                  if (rsp_ready_w[g]) begin
                     busy[g] = 0; rdy_exp[g] = 1; hs_n[g]++; hs_cyc[g] = cyc;
                     smax = (64'd1 << sw_of(g)) - 1;
                     if (exp_ops[g] < smax) exp_ops[g]++;
                     if (!exp_flag[g] && exp_inv[g] < smax) exp_inv[g]++;
                  end else begin
                     done_wait[g]++;
                  end
               end else begin
                  t[g]++;
               end
            end
            if (!rst_done[g] && busy[g] && acc_n[g] == 20 && t[g] == 3 && reset_n_w[g])
               want_rst[g] = 1;
         end

         // Mid-SEND asynchronous reset: outputs must clear before any clock edge
         if (want_rst[0] || want_rst[1]) begin
            #2;
            for (int g = 0; g < 2; g++) if (want_rst[g]) reset_n_w[g] = 1'b0;
            #1;
            for (int g = 0; g < 2; g++) begin
               if (want_rst[g]) begin
                  chk("async_chip_in",   g, 32'(chip_in_w[g]),   32'd0);
                  chk("async_rsp_valid", g, 32'(rsp_valid_w[g]), 32'd0);
                  chk("async_rsp_data",  g, 32'(rsp_data_w[g]),  32'd0);
                  busy[g] = 0; rdy_exp[g] = 0; exp_data[g] = '0; exp_flag[g] = 1'b0;
                  exp_ops[g] = 0; exp_inv[g] = 0; rst_hold[g] = 2; rst_done[g] = 1;
               end
            end
         end
      end

      for (int g = 0; g < 2; g++) begin
         if (acc_n[g] < N_TXN) chk("progress_timeout", g, 32'(acc_n[g]), 32'(N_TXN));
         if (!rst_done[g]) chk("reset_injected", g, 32'(rst_done[g]), 32'd1);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
